act_unit_scheduler: RTL and testbench

//  Shares one fixed-latency activation datapath (sigmoid or tanh, Q5.5 in, 10-bit out) among NUM_REQ requesters.

---
 rtl/act_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/act_unit_scheduler.sv | 177 +++++++++++++++++
 tb/tb_act_unit_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared constants for the activation scheduler: mode encodings, Q5.5 clamp
// limits and default operand/result widths.
package act_pkg;

  localparam int unsigned ACT_DATA_W_I = 10;
  localparam int unsigned ACT_DATA_W_O = 10;

  localparam logic MODE_SIGMOID = 1'b0;
  localparam logic MODE_TANH    = 1'b1;

  // +/-7.00 in Q5.5, the legal input range of the shared datapath
  localparam logic signed [ACT_DATA_W_I-1:0] SAT_POS = 10'sd224;
  localparam logic signed [ACT_DATA_W_I-1:0] SAT_NEG = -10'sd224;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves past the
// winner only when a grant is actually given.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int unsigned      cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    if (enable) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = 32'(ptr) + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!found && req[IDX_W'(cand)]) begin
          found                  = 1'b1;
          grant[IDX_W'(cand)]    = 1'b1;
          grant_idx              = IDX_W'(cand);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/act_unit_scheduler.sv
// Shares one fixed-latency activation datapath among NUM_REQ requesters:
// arbitrate, clamp, issue, track tags and return results through a FWFT FIFO.
module act_unit_scheduler
  import act_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W_I    = ACT_DATA_W_I,
  parameter int unsigned DATA_W_O    = ACT_DATA_W_O,
  parameter int unsigned ACT_LATENCY = 2,
  parameter int unsigned RSP_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         c_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ*DATA_W_I-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         act_issue,
  output logic                         act_mode,
  output logic [DATA_W_I-1:0]          act_data,
  input  logic [DATA_W_O-1:0]          act_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         rsp_mode,
  output logic [DATA_W_O-1:0]          rsp_data
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic                mode;
    logic [DATA_W_O-1:0] data;
  } rsp_entry_t;

  logic [CNT_W-1:0]    credit;
  logic                grant_en;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                xfer;
  logic                push;
  logic                pop;
  logic [DATA_W_I-1:0] sel_data;
  logic [DATA_W_I-1:0] sat_data;
  logic                sel_mode;
  logic [ID_W-1:0]     issue_id;

  logic [ACT_LATENCY-1:0] tag_valid;
  logic [ACT_LATENCY-1:0] tag_mode;
  logic [ID_W-1:0]        tag_id [ACT_LATENCY];

  rsp_entry_t       fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  rsp_entry_t       push_entry;
  rsp_entry_t       head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts everything issued but not yet popped, so the FIFO can never overflow
  assign grant_en  = c_en && !reset && (credit < CNT_W'(RSP_DEPTH));
  assign req_ready = grant;
  assign xfer      = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .enable    (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data[i*DATA_W_I +: DATA_W_I];
        sel_mode = req_mode[i];
      end
    end
  end

  always_comb begin
    sat_data = sel_data;
    if ($signed(sel_data) > SAT_POS)      sat_data = SAT_POS;
    else if ($signed(sel_data) < SAT_NEG) sat_data = SAT_NEG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_issue <= 1'b0;
      act_mode  <= MODE_SIGMOID;
      act_data  <= '0;
      issue_id  <= '0;
    end else begin
      act_issue <= xfer;
      if (xfer) begin
        act_mode <= sel_mode;
        act_data <= sat_data;
        issue_id <= grant_idx;
      end
    end
  end

  // Tag pipe: last stage lines up with act_result for the same operation
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_mode  <= '0;
      for (int unsigned k = 0; k < ACT_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_valid[0] <= act_issue;
      tag_mode[0]  <= act_mode;
      tag_id[0]    <= issue_id;
      for (int unsigned k = 1; k < ACT_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_mode[k]  <= tag_mode[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  assign push       = tag_valid[ACT_LATENCY-1];
  assign push_entry = '{id: tag_id[ACT_LATENCY-1], mode: tag_mode[ACT_LATENCY-1], data: act_result};

  // Empty FIFO bypasses the arriving result straight to the response port
  assign head      = (count == '0) ? push_entry : fifo_mem[rd_ptr];
  assign rsp_valid = !reset && ((count != '0) || push);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = rsp_valid ? head.id   : '0;
  assign rsp_mode  = rsp_valid ? head.mode : 1'b0;
  assign rsp_data  = rsp_valid ? head.data : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({xfer, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: tb/tb_act_unit_scheduler.sv
// Directed bench for act_unit_scheduler with a round-robin/credit reference
// model, an activation-unit stand-in and an in-order response scoreboard.
module tb_act_unit_scheduler;
  import act_pkg::*;

  localparam int NR = 4;
  localparam int DW = 10;
  localparam int L  = 2;
  localparam int D  = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic          mode;
    logic [DW-1:0] data;
  } rsp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             c_en;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_mode;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             act_issue;
  logic             act_mode;
  logic [DW-1:0]    act_data;
  logic [DW-1:0]    act_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic             rsp_mode;
  logic [DW-1:0]    rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  act_unit_scheduler #(
    .NUM_REQ(NR), .DATA_W_I(DW), .DATA_W_O(DW), .ACT_LATENCY(L), .RSP_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .c_en(c_en),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data), .req_ready(req_ready),
    .act_issue(act_issue), .act_mode(act_mode), .act_data(act_data), .act_result(act_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_mode(rsp_mode),
    .rsp_data(rsp_data)
  );

  function automatic logic [DW-1:0] act_ref(input logic [DW-1:0] d, input logic m);
    return m ? (d ^ 10'h155) : (d + 10'd37);
  endfunction

  function automatic logic [DW-1:0] sat_ref(input logic [DW-1:0] d);
    int v;
    v = int'($signed(d));
    if (v > 224)  return 10'h0E0;
    if (v < -224) return 10'h320;
    return d;
  endfunction

  function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) begin
      if (v[(p + i) % NR]) return NR'(1 << ((p + i) % NR));
    end
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stand-in for the shared activation unit; not reset, so stale results keep flowing
  logic [DW-1:0] emu [L];
  always @(posedge clk) begin
    emu[0] <= act_issue ? act_ref(act_data, act_mode) : 10'h3FF;
    for (int k = 1; k < L; k++) emu[k] <= emu[k-1];
  end
  assign act_result = emu[L-1];

  int            mptr = 0;
  int            mcred = 0;
  int            wait_cnt = 0;
  logic          pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic          pend_m = 1'b0;
  rsp_t          rsp_q[$];

  // Reference model and scoreboard, evaluated on the falling edge
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic          popped;
    int            win;
    exp_rdy = (reset || !c_en || mcred >= D) ? '0 : rr_pick(req_valid, mptr);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("act_issue", 32'(act_issue), 32'(pend_v));
    if (pend_v) begin
      check("act_data", 32'(act_data), 32'(pend_d));
      check("act_mode", 32'(act_mode), 32'(pend_m));
    end
    if (reset || rsp_q.size() == 0) begin
      check("rsp_spurious", 32'(rsp_valid), 32'(0));
    end else if (rsp_valid) begin
      check("rsp_payload", 32'({rsp_id, rsp_mode, rsp_data}), 32'(rsp_q[0]));
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      check("rsp_latency", 32'(wait_cnt <= L), 32'(1));
    end

    if (reset) begin
      mptr = 0; mcred = 0; pend_v = 1'b0; wait_cnt = 0;
      rsp_q.delete();
    end else begin
      popped = rsp_valid && rsp_ready;
      if (popped && rsp_q.size() != 0) void'(rsp_q.pop_front());
      if (rsp_q.size() == 0) wait_cnt = 0;
      pend_v = (exp_rdy != '0);
      if (pend_v) begin
        win = 0;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) win = i;
        pend_d = sat_ref(req_data[win*DW +: DW]);
        pend_m = req_mode[win];
        rsp_q.push_back('{id: 2'(win), mode: pend_m, data: act_ref(pend_d, pend_m)});
        mptr = (win + 1) % NR;
      end
      mcred = mcred + (pend_v ? 1 : 0) - (popped ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [DW-1:0] d, input logic m);
    logic done;
    done = 1'b0;
    req_data[idx*DW +: DW] = d;
    req_mode[idx]  = m;
    req_valid[idx] = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = req_ready[idx];
      step();
    end
    req_valid[idx] = 1'b0;
    check("send_grant", 32'(done), 32'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (rsp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    check("drain_empty", 32'(rsp_q.size()), 32'(0));
  endtask

  initial begin
    int n;
    int lat;
    reset = 1'b1; c_en = 1'b1; rsp_ready = 1'b1;
    req_valid = 4'hF; req_mode = '0; req_data = '0;
    repeat (3) step();

    // Reset state with requests pending
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_act_issue", 32'(act_issue), 32'(0));
    check("rst_act_mode",  32'(act_mode),  32'(0));
    check("rst_act_data",  32'(act_data),  32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id",    32'(rsp_id),    32'(0));
    check("rst_rsp_data",  32'(rsp_data),  32'(0));
    req_valid = '0;
    step();
    reset = 1'b0;
    step();

    // Single tanh request of 1.0
    send(0, 10'd32, MODE_TANH);
    @(negedge clk);
    check("b_act_issue", 32'(act_issue), 32'(1));
    check("b_act_data",  32'(act_data),  32'(32));
    lat = -1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("b_latency",  32'(lat),      32'(L));
    check("b_rsp_id",   32'(rsp_id),   32'(0));
    check("b_rsp_mode", 32'(rsp_mode), 32'(MODE_TANH));
    check("b_rsp_data", 32'(rsp_data), 32'(act_ref(10'd32, MODE_TANH)));
    step();
    drain();

    // Saturation boundaries
    send(1, 10'd256, MODE_SIGMOID);
    @(negedge clk); check("c_sat_pos", 32'(act_data), 32'(10'h0E0)); step();
    send(2, 10'h2E0, MODE_TANH);
    @(negedge clk); check("c_sat_neg", 32'(act_data), 32'(10'h320)); step();
    send(3, 10'h320, MODE_SIGMOID);
    @(negedge clk); check("c_pass_neg7", 32'(act_data), 32'(10'h320)); step();
    drain();

    // Continuous requests from all four, full throughput
    req_data = {10'd100, 10'd300, 10'h3D8, 10'd16};
    req_mode = 4'b1010;
    req_valid = 4'hF;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      step();
    end
    req_valid = '0;
    check("d_grant_count", 32'(n), 32'(16));
    drain();

    // Back-pressure: credit limits outstanding work to the FIFO depth
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      step();
    end
    @(negedge clk);
    check("e_grant_count", 32'(n), 32'(D));
    check("e_ready_block", 32'(req_ready), 32'(0));
    check("e_rsp_held",    32'(rsp_valid), 32'(1));
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // Issue enable dropped with two ops in flight
    send(0, 10'd64, MODE_SIGMOID);
    send(1, 10'd96, MODE_TANH);
    c_en = 1'b0;
    req_valid = 4'hF;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      step();
    end
    check("f_no_grant", 32'(n), 32'(0));
    check("f_drained",  32'(rsp_q.size()), 32'(0));
    c_en = 1'b1;
    @(negedge clk);
    check("f_ptr_kept", 32'(req_ready), 32'(4'b0100));
    step();
    req_valid = '0;
    drain();

    // Reset one cycle after an issue; the stale result must be dropped
    send(2, 10'd50, MODE_TANH);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("g_act_issue", 32'(act_issue), 32'(0));
    check("g_act_data",  32'(act_data),  32'(0));
    check("g_rsp_valid", 32'(rsp_valid), 32'(0));
    check("g_rsp_data",  32'(rsp_data),  32'(0));
    step();
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) n++;
      step();
    end
    check("g_no_stale", 32'(n), 32'(0));
    send(3, 10'd10, MODE_SIGMOID);
    drain();

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
